// File: rtl/vending_controller.sv
// Coin-operated vending controller: saturating credit, one-hot product select,
// cancel/refund, and paced coin-by-coin change output.
module vending_controller #(
  parameter int CREDIT_WIDTH = 8,
  parameter int PRODUCTS     = 4,
  parameter int BASE_PRICE   = 15,
  parameter int PRICE_STEP   = 5,
  parameter int MAX_CREDIT   = 35,
  parameter int NICKEL       = 5,
  parameter int DIME         = 10,
  parameter int QUARTER      = 25,
  parameter int DISPENSE_GAP = 2,
  localparam int PIDX_W = (PRODUCTS > 1) ? $clog2(PRODUCTS) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [2:0]              button,
  input  logic                    cancel,
  input  logic [PRODUCTS-1:0]     switch,
  output logic [CREDIT_WIDTH-1:0] amount,
  output logic [CREDIT_WIDTH-1:0] cost,
  output logic                    vend,
  output logic [PIDX_W-1:0]       product,
  output logic [2:0]              coin_out,
  output logic                    busy
);

  localparam int SUM_W = CREDIT_WIDTH + 1;
  localparam int GAP_W = (DISPENSE_GAP > 1) ? $clog2(DISPENSE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(DISPENSE_GAP - 1);

  if (MAX_CREDIT >= (2 ** CREDIT_WIDTH)) begin : g_bad_cap
    $error("MAX_CREDIT does not fit in CREDIT_WIDTH");
  end
  if ((BASE_PRICE + (PRODUCTS - 1) * PRICE_STEP) >= (2 ** CREDIT_WIDTH)) begin : g_bad_price
    $error("highest product price does not fit in CREDIT_WIDTH");
  end
  if (DISPENSE_GAP < 1) begin : g_bad_gap
    $error("DISPENSE_GAP must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_VEND    = 2'd1,
    ST_CHANGE  = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [2:0]              prev_r;
  logic [GAP_W-1:0]        gap_cnt_r, gap_cnt_nxt_s;
  logic [CREDIT_WIDTH-1:0] amount_nxt_s;
  logic                    vend_nxt_s;
  logic [PIDX_W-1:0]       product_nxt_s;
  logic [2:0]              coin_nxt_s;

  logic [2:0]              edge_s;
  logic [SUM_W-1:0]        coin_val_s, sum_s;
  logic [CREDIT_WIDTH-1:0] sat_s;
  logic                    sel_valid_s;
  logic [PIDX_W-1:0]       sel_idx_s;
  logic [SUM_W-1:0]        sel_price_s;
  logic                    cancel_take_s, buy_s;
  logic [2:0]              chg_coin_s;
  logic [CREDIT_WIDTH-1:0] chg_val_s;

  function automatic logic [SUM_W-1:0] price_of(input logic [PIDX_W-1:0] idx);
    return SUM_W'(BASE_PRICE) + SUM_W'(idx) * SUM_W'(PRICE_STEP);
  endfunction

  // Input decode: coin edges, saturated credit, product selection and change coin.
  always_comb begin
    edge_s = button & ~prev_r;
    case (edge_s)
      3'b001:  coin_val_s = SUM_W'(NICKEL);
      3'b010:  coin_val_s = SUM_W'(DIME);
      3'b100:  coin_val_s = SUM_W'(QUARTER);
      default: coin_val_s = '0;
    endcase
    sum_s = {1'b0, amount} + coin_val_s;
    sat_s = (sum_s > SUM_W'(MAX_CREDIT)) ? CREDIT_WIDTH'(MAX_CREDIT) : sum_s[CREDIT_WIDTH-1:0];

    sel_valid_s = $onehot(switch);
    sel_idx_s   = '0;
    for (int i = 0; i < PRODUCTS; i++) begin
      sel_idx_s = sel_idx_s | (switch[i] ? PIDX_W'(i) : PIDX_W'(0));
    end
    sel_price_s = price_of(sel_idx_s);
    cost        = sel_valid_s ? sel_price_s[CREDIT_WIDTH-1:0] : '0;

    cancel_take_s = cancel && (amount != '0);
    buy_s = (edge_s == 3'b000) && sel_valid_s && ({1'b0, amount} >= sel_price_s);

    if (amount >= CREDIT_WIDTH'(QUARTER)) begin
      chg_coin_s = 3'b100;
      chg_val_s  = CREDIT_WIDTH'(QUARTER);
    end else if (amount >= CREDIT_WIDTH'(DIME)) begin
      chg_coin_s = 3'b010;
      chg_val_s  = CREDIT_WIDTH'(DIME);
    end else if (amount >= CREDIT_WIDTH'(NICKEL)) begin
      chg_coin_s = 3'b001;
      chg_val_s  = CREDIT_WIDTH'(NICKEL);
    end else begin
      chg_coin_s = 3'b000;
      chg_val_s  = '0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_COLLECT: begin
        if (cancel_take_s) begin
          state_nxt_s = ST_CHANGE;
        end else if (buy_s) begin
          state_nxt_s = ST_VEND;
        end else begin
          state_nxt_s = ST_COLLECT;
        end
      end
      ST_VEND:   state_nxt_s = (amount != '0) ? ST_CHANGE : ST_COLLECT;
      ST_CHANGE: state_nxt_s = (chg_val_s != '0) ? ST_GAP : ST_COLLECT;
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_nxt_s = (amount != '0) ? ST_CHANGE : ST_COLLECT;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: state_nxt_s = ST_COLLECT;
    endcase
  end

  // Next values of the registered outputs; a cancel keeps the credit as the refund.
  always_comb begin
    amount_nxt_s  = amount;
    vend_nxt_s    = 1'b0;
    product_nxt_s = product;
    coin_nxt_s    = 3'b000;
    gap_cnt_nxt_s = gap_cnt_r;
    case (state_r)
      ST_COLLECT: begin
        if (cancel_take_s) begin
          amount_nxt_s = amount;
        end else if ($onehot(edge_s)) begin
          amount_nxt_s = sat_s;
        end else if (buy_s) begin
          amount_nxt_s  = amount - sel_price_s[CREDIT_WIDTH-1:0];
          vend_nxt_s    = 1'b1;
          product_nxt_s = sel_idx_s;
        end else begin
          amount_nxt_s = amount;
        end
      end
      ST_VEND: amount_nxt_s = amount;
      ST_CHANGE: begin
        // A sub-nickel residue cannot be paid out and is dropped.
        amount_nxt_s  = (chg_val_s != '0) ? (amount - chg_val_s) : '0;
        coin_nxt_s    = chg_coin_s;
        gap_cnt_nxt_s = '0;
      end
      ST_GAP:  gap_cnt_nxt_s = gap_cnt_r + GAP_W'(1);
      default: amount_nxt_s = '0;
    endcase
  end

  // State and output registers; everything advances only on enable ticks.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_COLLECT;
      prev_r    <= 3'b111;
      gap_cnt_r <= '0;
      amount    <= '0;
      vend      <= 1'b0;
      product   <= '0;
      coin_out  <= 3'b000;
      busy      <= 1'b0;
    end else if (enable) begin
      state_r   <= state_nxt_s;
      prev_r    <= button;
      gap_cnt_r <= gap_cnt_nxt_s;
      amount    <= amount_nxt_s;
      vend      <= vend_nxt_s;
      product   <= product_nxt_s;
      coin_out  <= coin_nxt_s;
      busy      <= (state_nxt_s != ST_COLLECT);
    end
  end

endmodule

// File: tb/tb_vending_controller.sv
// Self-checking bench for vending_controller: directed scenarios plus random
// stimulus against a transaction-level model that scripts busy periods.
module tb_vending_controller;
  localparam int W = 8;
  localparam int P = 4;
  localparam int GAP = 2;
  localparam int CAP = 35;

  logic         clock = 1'b0;
  logic         reset, enable, cancel;
  logic [2:0]   button;
  logic [P-1:0] switch;
  logic [W-1:0] amount, cost;
  logic         vend, busy;
  logic [1:0]   product;
  logic [2:0]   coin_out;

  vending_controller dut (
    .clock(clock), .reset(reset), .enable(enable), .button(button),
    .cancel(cancel), .switch(switch), .amount(amount), .cost(cost),
    .vend(vend), .product(product), .coin_out(coin_out), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int amt;
    int coin;
    bit vnd;
    bit bsy;
  } ev_t;

  ev_t        script[$];
  int         m_amt, m_prod, m_coin;
  bit         m_vend, m_busy;
  logic [2:0] m_prev;
  int         n_checks = 0;
  int         n_errors = 0;
  int         pulses, vends;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int price(input int i);
    return 15 + 5 * i;
  endfunction

  function automatic int sel_index(input logic [P-1:0] s);
    if ($countones(s) != 1) return -1;
    for (int i = 0; i < P; i++) if (s[i]) return i;
    return -1;
  endfunction

  function automatic ev_t mk_ev(input int a, input int c, input bit v, input bit b);
    ev_t e;
    e.amt = a; e.coin = c; e.vnd = v; e.bsy = b;
    return e;
  endfunction

  // Greedy change as a script: a pulse, then GAP idle ticks, per coin.
  task automatic push_change(input int r0);
    int r, val, code;
    r = r0;
    while (r > 0) begin
      if (r < 5) begin
        script.push_back(mk_ev(0, 0, 1'b0, 1'b0));
        break;
      end
      if (r >= 25) begin val = 25; code = 4; end
      else if (r >= 10) begin val = 10; code = 2; end
      else begin val = 5; code = 1; end
      r -= val;
      script.push_back(mk_ev(r, code, 1'b0, 1'b1));
      for (int g = 0; g < GAP; g++)
        script.push_back(mk_ev(r, 0, 1'b0, (g < GAP - 1) || (r > 0)));
    end
  endtask

  task automatic model_reset();
    m_amt = 0; m_prod = 0; m_coin = 0; m_vend = 1'b0; m_busy = 1'b0;
    m_prev = 3'b111;
    script.delete();
  endtask

  task automatic model_tick();
    logic [2:0] e;
    int idx, v;
    ev_t ev;
    e = button & ~m_prev;
    m_prev = button;
    m_vend = 1'b0;
    m_coin = 0;
    if (script.size() > 0) begin
      ev = script.pop_front();
      m_amt = ev.amt; m_coin = ev.coin; m_vend = ev.vnd; m_busy = ev.bsy;
    end else begin
      m_busy = 1'b0;
      idx = sel_index(switch);
      if (cancel && m_amt > 0) begin
        m_busy = 1'b1;
        push_change(m_amt);
      end else if (e != 3'b000) begin
        if ($countones(e) == 1) begin
          v = e[0] ? 5 : (e[1] ? 10 : 25);
          m_amt = (m_amt + v > CAP) ? CAP : m_amt + v;
        end
      end else if (idx >= 0 && m_amt >= price(idx)) begin
        m_amt -= price(idx);
        m_vend = 1'b1; m_busy = 1'b1; m_prod = idx;
        if (m_amt == 0) begin
          script.push_back(mk_ev(0, 0, 1'b0, 1'b0));
        end else begin
          script.push_back(mk_ev(m_amt, 0, 1'b0, 1'b1));
          push_change(m_amt);
        end
      end
    end
  endtask

  task automatic step();
    int idx;
    @(posedge clock);
    if (reset) model_reset();
    else if (enable) model_tick();
    #1;
    idx = sel_index(switch);
    check_eq("amount", 32'(amount), m_amt);
    check_eq("vend", 32'(vend), 32'(m_vend));
    check_eq("product", 32'(product), m_prod);
    check_eq("coin_out", 32'(coin_out), m_coin);
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("cost", 32'(cost), (idx >= 0) ? price(idx) : 0);
    if (coin_out != 3'b000) pulses++;
    if (vend) vends++;
  endtask

  task automatic cyc(input logic [2:0] b, input logic c, input logic [P-1:0] s);
    button = b; cancel = c; switch = s;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(3'b000, 1'b0, 4'b0000);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; cancel = 1'b0; button = 3'b000; switch = '0;
    model_reset();
    step(); step();
    check_eq("reset_amount", 32'(amount), 0);
    check_eq("reset_busy", 32'(busy), 0);
    reset = 1'b0;

    // 1: nickel, dime, buy product 0 with exact credit
    idle(1);
    cyc(3'b001, 1'b0, 4'b0000); check_eq("t1_amt5", 32'(amount), 5);
    cyc(3'b000, 1'b0, 4'b0000);
    cyc(3'b010, 1'b0, 4'b0000); check_eq("t1_amt15", 32'(amount), 15);
    cyc(3'b000, 1'b0, 4'b0001);
    check_eq("t1_vend", 32'(vend), 1); check_eq("t1_cost", 32'(cost), 15);
    check_eq("t1_amt0", 32'(amount), 0);
    pulses = 0; idle(4);
    check_eq("t1_no_coin", pulses, 0); check_eq("t1_idle", 32'(busy), 0);

    // 2: saturation at the cap, then two dime pulses of change
    cyc(3'b100, 1'b0, 4'b0000); check_eq("t2_amt25", 32'(amount), 25);
    cyc(3'b000, 1'b0, 4'b0000);
    cyc(3'b100, 1'b0, 4'b0000); check_eq("t2_sat35", 32'(amount), 35);
    cyc(3'b000, 1'b0, 4'b0001); check_eq("t2_amt20", 32'(amount), 20);
    pulses = 0; idle(10);
    check_eq("t2_pulses", pulses, 2); check_eq("t2_amt0", 32'(amount), 0);

    // 3: cancel refunds 30 as quarter then nickel
    cyc(3'b100, 1'b0, 4'b0000); cyc(3'b000, 1'b0, 4'b0000);
    cyc(3'b001, 1'b0, 4'b0000); check_eq("t3_amt30", 32'(amount), 30);
    pulses = 0; vends = 0;
    cyc(3'b000, 1'b1, 4'b0000); check_eq("t3_busy", 32'(busy), 1);
    cyc(3'b000, 1'b0, 4'b0000); check_eq("t3_quarter", 32'(coin_out), 4);
    check_eq("t3_amt5", 32'(amount), 5);
    idle(8);
    check_eq("t3_pulses", pulses, 2); check_eq("t3_no_vend", vends, 0);

    // 4: simultaneous coin edges, and a quarter held through reset
    cyc(3'b001, 1'b0, 4'b0000); cyc(3'b000, 1'b0, 4'b0000);
    cyc(3'b011, 1'b0, 4'b0000); check_eq("t4_multi", 32'(amount), 5);
    button = 3'b100; reset = 1'b1; step(); reset = 1'b0;
    cyc(3'b100, 1'b0, 4'b0000); cyc(3'b100, 1'b0, 4'b0000);
    check_eq("t4_held", 32'(amount), 0);

    // 5: coin edge beats a same-tick selection
    cyc(3'b000, 1'b0, 4'b0000);
    cyc(3'b010, 1'b0, 4'b0000); cyc(3'b000, 1'b0, 4'b0000);
    cyc(3'b001, 1'b0, 4'b0000); cyc(3'b000, 1'b0, 4'b0000);
    cyc(3'b010, 1'b0, 4'b0001);
    check_eq("t5_amt25", 32'(amount), 25); check_eq("t5_novend", 32'(vend), 0);
    cyc(3'b010, 1'b0, 4'b0001); check_eq("t5_vend", 32'(vend), 1);
    pulses = 0; idle(8); check_eq("t5_pulses", pulses, 1);

    // 6: reset during the first gap, then a disabled stretch
    cyc(3'b100, 1'b0, 4'b0000); cyc(3'b000, 1'b0, 4'b0000);
    cyc(3'b100, 1'b0, 4'b0000); cyc(3'b000, 1'b0, 4'b0001);
    idle(2); check_eq("t6_in_gap", 32'(amount), 10);
    reset = 1'b1; step(); reset = 1'b0;
    check_eq("t6_rst_amt", 32'(amount), 0); check_eq("t6_rst_busy", 32'(busy), 0);
    idle(1); cyc(3'b001, 1'b0, 4'b0000); cyc(3'b000, 1'b0, 4'b0000);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) cyc(3'(i % 8), 1'b0, 4'b0000);
    check_eq("t6_hold", 32'(amount), 5);
    enable = 1'b1;

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      reset  = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 4) != 0);
      cancel = ($urandom_range(0, 24) == 0);
      button = ($urandom_range(0, 2) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
      if ($urandom_range(0, 7) == 0) button = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) switch = 4'(1 << $urandom_range(0, 3));
      else switch = 4'($urandom_range(0, 15));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
